keypad_scan_queue: RTL and testbench

Parametrised keypad front end: drives one-hot row strobes across an R×C matrix, synchronises and debounces the column returns, and encodes each debounced press as a binary key code. Codes are pushed into a small valid/ready FIFO, so the display or consumer logic never misses a keypress. It replaces the fixed 4×4 scanner, synchroniser and debouncer chain, and adds multi-key rejection, release tracking and overflow reporting.

---
 rtl/keypad_scan_queue.sv | 219 +++++++++++++++++++++
 tb/tb_keypad_scan_queue.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan_queue.sv
`default_nettype none
// ============================================================================
//  Module      : keypad_scan_queue
//  Description : Row-strobed R x C keypad scanner with column synchroniser,
//                press/release debounce, multi-key rejection and a small
//                valid/ready FIFO of binary key codes.
//  Revision    : 1.0  initial release
// ============================================================================
module keypad_scan_queue #(
    parameter int ROWS     = 4,
    parameter int COLS     = 4,
    parameter int DWELL    = 4,
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 4,
    localparam int KW      = $clog2(ROWS*COLS)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [COLS-1:0] async_col,
    output logic [ROWS-1:0] row,
    output logic            key_valid,
    output logic [KW-1:0]   key_code,
    input  logic            key_ready,
    output logic            multi,
    output logic            overflow
);

    localparam int C_RW = $clog2(ROWS);
    localparam int C_CW = $clog2(COLS);
    localparam int C_DW = $clog2(DWELL);
    localparam int C_BW = $clog2(DEBOUNCE + 1);
    localparam int C_AW = $clog2(DEPTH);
    localparam int C_NW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_SCAN    = 2'd0,
        S_CONFIRM = 2'd1,
        S_HELD    = 2'd2
    } state_t;

    state_t            r_state;
    logic [COLS-1:0]   r_col_m;
    logic [COLS-1:0]   r_col_s;
    logic [ROWS-1:0]   r_row;
    logic [C_RW-1:0]   r_row_idx;
    logic [C_DW-1:0]   r_dwell;
    logic [C_RW-1:0]   r_cand_row;
    logic [C_CW-1:0]   r_cand_col;
    logic [C_BW-1:0]   r_cnt;
    logic              r_multi;

    logic [KW-1:0]     r_mem [DEPTH];
    logic [C_AW-1:0]   r_wr;
    logic [C_AW-1:0]   r_rd;
    logic [C_NW-1:0]   r_fcnt;
    logic              r_key_valid;
    logic [KW-1:0]     r_key_code;
    logic              r_overflow;

    logic              w_any;
    logic              w_many;
    logic [C_CW-1:0]   w_idx;
    logic              w_last_dwell;
    logic [C_RW-1:0]   w_next_row;
    logic [COLS-1:0]   w_cand_mask;
    logic              w_match;
    logic              w_push;
    logic [KW-1:0]     w_code;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic              w_drop;
    logic [C_AW-1:0]   w_rd_next;
    logic [C_NW-1:0]   w_fcnt_next;
    logic [C_NW-1:0]   w_remain;
    logic [KW-1:0]     w_head_next;

    // Two-flop synchroniser on the raw column returns
    always_ff @(posedge clk) begin
        if (reset) begin
            r_col_m <= '0;
            r_col_s <= '0;
        end else begin
            r_col_m <= async_col;
            r_col_s <= r_col_m;
        end
    end

    // Column decode, candidate match and the push request into the FIFO
    always_comb begin
        w_any  = 1'b0;
        w_many = 1'b0;
        w_idx  = '0;
        for (int c = 0; c < COLS; c++) begin
            if (r_col_s[c]) begin
                if (w_any) w_many = 1'b1;
                w_any = 1'b1;
                w_idx = C_CW'(c);
            end
        end
        w_last_dwell = (r_dwell == C_DW'(DWELL - 1));
        w_next_row   = (r_row_idx == C_RW'(ROWS - 1)) ? '0 : r_row_idx + 1'b1;
        w_cand_mask  = COLS'(1) << r_cand_col;
        w_match      = (r_col_s == w_cand_mask);
        // Push on the DEBOUNCE-th matching sample so key_valid follows one edge later
        w_push       = (r_state == S_CONFIRM) && w_match && (r_cnt == C_BW'(DEBOUNCE - 1));
        w_code       = KW'(int'(r_cand_row) * COLS + int'(r_cand_col));
    end

    // Scan / confirm / held state machine driving the row strobes
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_SCAN;
            r_row      <= ROWS'(1);
            r_row_idx  <= '0;
            r_dwell    <= '0;
            r_cand_row <= '0;
            r_cand_col <= '0;
            r_cnt      <= '0;
            r_multi    <= 1'b0;
        end else begin
            r_multi <= 1'b0;
            case (r_state)
                S_SCAN: begin
                    if (w_last_dwell) begin
                        r_dwell <= '0;
                        if (w_any && !w_many) begin
                            r_cand_row <= r_row_idx;
                            r_cand_col <= w_idx;
                            r_cnt      <= '0;
                            r_state    <= S_CONFIRM;
                        end else begin
                            r_multi   <= w_many;
                            r_row_idx <= w_next_row;
                            r_row     <= ROWS'(1) << w_next_row;
                        end
                    end else begin
                        r_dwell <= r_dwell + 1'b1;
                    end
                end
                S_CONFIRM: begin
                    if (!w_match) begin
                        r_state   <= S_SCAN;
                        r_dwell   <= '0;
                        r_row_idx <= w_next_row;
                        r_row     <= ROWS'(1) << w_next_row;
                    end else if (w_push) begin
                        r_state <= S_HELD;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HELD: begin
                    // Only the candidate column matters until it has been released
                    if (r_col_s[r_cand_col]) begin
                        r_cnt <= '0;
                    end else if (r_cnt == C_BW'(DEBOUNCE - 1)) begin
                        r_state   <= S_SCAN;
                        r_cnt     <= '0;
                        r_dwell   <= '0;
                        r_row_idx <= w_next_row;
                        r_row     <= ROWS'(1) << w_next_row;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= S_SCAN;
                end
            endcase
        end
    end

    // FIFO next-state: a pop frees a slot for a same-cycle push even when full
    always_comb begin
        w_pop       = r_key_valid & key_ready;
        w_full      = (r_fcnt == C_NW'(DEPTH));
        w_push_ok   = w_push & (~w_full | w_pop);
        w_drop      = w_push & w_full & ~w_pop;
        w_rd_next   = r_rd + C_AW'(w_pop);
        w_fcnt_next = r_fcnt + C_NW'(w_push_ok) - C_NW'(w_pop);
        w_remain    = r_fcnt - C_NW'(w_pop);
        // When nothing older survives the pop, the new head is the code being pushed
        w_head_next = (w_remain == '0) ? w_code : r_mem[w_rd_next];
    end

    // FIFO storage array (pointers carry the valid state, so no reset needed)
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr] <= w_code;
    end

    // FIFO pointers, count and registered head/overflow outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr        <= '0;
            r_rd        <= '0;
            r_fcnt      <= '0;
            r_key_valid <= 1'b0;
            r_key_code  <= '0;
            r_overflow  <= 1'b0;
        end else begin
            if (w_push_ok) r_wr <= r_wr + 1'b1;
            r_rd        <= w_rd_next;
            r_fcnt      <= w_fcnt_next;
            r_key_valid <= (w_fcnt_next != '0);
            r_key_code  <= (w_fcnt_next != '0) ? w_head_next : '0;
            r_overflow  <= w_drop;
        end
    end

    assign row       = r_row;
    assign key_valid = r_key_valid;
    assign key_code  = r_key_code;
    assign multi     = r_multi;
    assign overflow  = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_keypad_scan_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_keypad_scan_queue
//  Description : Scoreboard bench for keypad_scan_queue (4x4 and 2x3 builds)
//                with a behavioural keypad model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_keypad_scan_queue;

    localparam int ROWS = 4, COLS = 4, KW = 4;
    localparam int R2 = 2, C2 = 3, KW2 = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 reset;
    logic [COLS-1:0]      async_col;
    logic [ROWS-1:0]      row;
    logic                 key_valid;
    logic [KW-1:0]        key_code;
    logic                 key_ready;
    logic                 multi;
    logic                 overflow;
    logic [ROWS*COLS-1:0] held;

    logic [C2-1:0]        async_col2;
    logic [R2-1:0]        row2;
    logic                 key_valid2;
    logic [KW2-1:0]       key_code2;
    logic                 key_ready2;
    logic                 multi2;
    logic                 overflow2;
    logic [R2*C2-1:0]     held2;

    int n_cmp = 0, n_bad = 0;
    int pops = 0, pops2 = 0, multi_cnt = 0, ovf_cnt = 0;
    int ready_mode = 1;          // 0 low, 1 high, 2 random
    int sbq[$];
    int sbq2[$];

    keypad_scan_queue dut (
        .clk(clk), .reset(reset), .async_col(async_col), .row(row),
        .key_valid(key_valid), .key_code(key_code), .key_ready(key_ready),
        .multi(multi), .overflow(overflow)
    );

    keypad_scan_queue #(.ROWS(R2), .COLS(C2)) dut2 (
        .clk(clk), .reset(reset), .async_col(async_col2), .row(row2),
        .key_valid(key_valid2), .key_code(key_code2), .key_ready(key_ready2),
        .multi(multi2), .overflow(overflow2)
    );

    // Keypad matrix: a held key connects its row strobe to its column return
    always_comb begin
        async_col = '0;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (held[r*COLS + c] && row[r]) async_col[c] = 1'b1;
        async_col2 = '0;
        for (int r = 0; r < R2; r++)
            for (int c = 0; c < C2; c++)
                if (held2[r*C2 + c] && row2[r]) async_col2[c] = 1'b1;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // key_ready driver
    initial begin
        key_ready  = 1'b1;
        key_ready2 = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       key_ready = 1'b0;
                1:       key_ready = 1'b1;
                default: key_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every accepted head is checked against the scoreboard
    always @(negedge clk) begin
        if (!reset) begin
            if (key_valid && key_ready) begin
                pops++;
                if (sbq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pop: got code %0d expected no entry at %0t", key_code, $time);
                end else begin
                    check("pop_code", int'(key_code), sbq.pop_front());
                end
            end
            if (key_valid2 && key_ready2) begin
                pops2++;
                if (sbq2.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_pop2: got code %0d expected no entry at %0t", key_code2, $time);
                end else begin
                    check("pop_code2", int'(key_code2), sbq2.pop_front());
                end
            end
            if (!key_valid) check("code_zero_when_idle", int'(key_code), 0);
            if (multi) multi_cnt++;
            if (overflow) ovf_cnt++;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int p0, m0, o0, t, r, c;
        int codes[5];
        codes = '{3, 4, 5, 6, 10};
        reset = 1'b1;
        held  = '0;
        held2 = '0;
        tick(3);
        reset = 1'b0;

        // Reset state, then the idle row rotation
        check("reset_row", int'(row), 1);
        check("reset_key_valid", int'(key_valid), 0);
        check("reset_key_code", int'(key_code), 0);
        check("reset_multi", int'(multi), 0);
        check("reset_overflow", int'(overflow), 0);
        for (int k = 1; k < 20; k++) begin
            tick(1);
            check("idle_row", int'(row), 1 << ((k / 4) % 4));
        end
        check("idle_key_valid", int'(key_valid), 0);
        check("idle_pulses", multi_cnt + ovf_cnt, 0);

        // Long hold, release, press again: one code per press
        p0 = pops;
        held[2*COLS + 1] = 1'b1;
        sbq.push_back(2*COLS + 1);
        t = 0;
        while (!key_valid && t < 40) begin
            tick(1);
            t++;
        end
        check("press_latency_within_23", int'(t <= 23), 1);
        tick(200 - t);
        held = '0;
        tick(40);
        held[2*COLS + 1] = 1'b1;
        sbq.push_back(2*COLS + 1);
        tick(60);
        held = '0;
        tick(40);
        check("long_hold_pops", pops - p0, 2);

        // Bouncing key produces nothing until it settles
        p0 = pops;
        for (int i = 0; i < 10; i++) begin
            held[1*COLS + 3] = 1'b1;
            tick(2);
            held[1*COLS + 3] = 1'b0;
            tick(2);
        end
        check("bounce_no_push", pops - p0, 0);
        held[1*COLS + 3] = 1'b1;
        sbq.push_back(1*COLS + 3);
        tick(60);
        held = '0;
        tick(30);
        check("bounce_settled_pops", pops - p0, 1);

        // Two keys in row 0: one multi pulse per row-0 visit, then single key
        p0 = pops;
        held[0] = 1'b1;
        held[2] = 1'b1;
        tick(20);
        m0 = multi_cnt;
        tick(64);
        check("multi_pulses", multi_cnt - m0, 4);
        check("multi_no_push", pops - p0, 0);
        held[2] = 1'b0;
        sbq.push_back(0);
        tick(60);
        held = '0;
        tick(30);
        check("multi_release_pops", pops - p0, 1);

        // Overflow with consumer stalled
        ready_mode = 0;
        tick(1);
        p0 = pops;
        o0 = ovf_cnt;
        for (int i = 0; i < 5; i++) begin
            held[codes[i]] = 1'b1;
            if (i < 4) sbq.push_back(codes[i]);
            tick(45);
            held = '0;
            tick(30);
        end
        check("overflow_pulses", ovf_cnt - o0, 1);
        check("full_key_valid", int'(key_valid), 1);
        check("full_head_code", int'(key_code), 3);
        ready_mode = 1;
        tick(20);
        check("drain_pops", pops - p0, 4);
        check("drained_key_valid", int'(key_valid), 0);

        // Reset while a key is held with two entries queued
        ready_mode = 0;
        tick(1);
        held[1] = 1'b1;
        sbq.push_back(1);
        tick(45);
        held = '0;
        tick(30);
        held[2] = 1'b1;
        sbq.push_back(2);
        tick(45);
        check("pre_reset_key_valid", int'(key_valid), 1);
        check("pre_reset_head", int'(key_code), 1);
        held  = '0;
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        sbq.delete();
        check("post_reset_key_valid", int'(key_valid), 0);
        check("post_reset_row", int'(row), 1);
        check("post_reset_code", int'(key_code), 0);
        p0 = pops;
        ready_mode = 1;
        tick(40);
        check("post_reset_no_pop", pops - p0, 0);

        // Randomised presses with a randomly stalling consumer
        ready_mode = 2;
        o0 = ovf_cnt;
        for (int i = 0; i < 10; i++) begin
            r = $urandom_range(0, ROWS - 1);
            c = $urandom_range(0, COLS - 1);
            held[r*COLS + c] = 1'b1;
            sbq.push_back(r*COLS + c);
            tick($urandom_range(35, 70));
            held = '0;
            tick($urandom_range(25, 45));
        end
        ready_mode = 1;
        t = 0;
        while (sbq.size() != 0 && t < 100) begin
            tick(1);
            t++;
        end
        check("random_drained", sbq.size(), 0);
        check("random_no_overflow", ovf_cnt - o0, 0);

        // 2x3 build: key (1,2) pressed twice
        p0 = pops2;
        held2[1*C2 + 2] = 1'b1;
        sbq2.push_back(1*C2 + 2);
        tick(60);
        held2 = '0;
        tick(30);
        held2[1*C2 + 2] = 1'b1;
        sbq2.push_back(1*C2 + 2);
        tick(60);
        held2 = '0;
        tick(30);
        check("small_pops", pops2 - p0, 2);
        check("small_queue_empty", sbq2.size(), 0);
        check("small_key_valid", int'(key_valid2), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
